instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Holds the program counter and fetches one 32-bit instruction word at a time over a
//   valid/ready instruction-memory port. Presents each word, with its PC, to the decode
//   stage (the control extractor and its operand/immediate logic) through a valid/ready
//   handshake. Accepts PC redirects from the branch/jump resolution logic and discards
//   stale in-flight fetches.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC loaded on reset; bits [1:0] must be 0
//   NOP_INSTR  32'h0000_0013   value driven on instr when nothing is held (addi x0,x0,0)
// PORTS
//   clk              in   1   single clock, all state updates on rising edge
//   reset_n          in   1   synchronous, active-low reset
//   redirect_valid   in   1   pulse: the next fetch comes from redirect_pc
//   redirect_pc      in   32  target PC; bits [1:0] ignored (forced 0)
//   imem_req_valid   out  1   fetch request valid
//   imem_req_ready   in   1   memory accepts the request this cycle
//   imem_req_addr    out  32  word-aligned fetch address
//   imem_resp_valid  in   1   response word valid (exactly one per accepted request)
//   imem_resp_data   in   32  fetched instruction word
//   instr_valid      out  1   instr/instr_pc hold a fetched instruction
//   instr_ready      in   1   decode consumes instr this cycle
//   instr            out  32  instruction word to decode
//   instr_pc         out  32  PC of instr
// BEHAVIOUR
//   Reset (reset_n=0 at an edge): pc=RESET_PC, state=S_REQ, drop=0, instr_valid=0,
//     instr=NOP_INSTR, instr_pc=0. During the reset cycle imem_req_valid=0 (gated by reset_n).
//     Reset mid-operation abandons everything. The memory shares this reset, so no
//     pre-reset response arrives afterwards. Any response seen in S_REQ/S_HOLD is ignored.
//   States, one-hot or encoded, registered:
//     S_REQ : imem_req_valid=1, imem_req_addr=pc. On imem_req_ready go to S_WAIT.
//     S_WAIT: on imem_resp_valid: instr<=data, instr_pc<=pc, pc<=pc+4, instr_valid<=1, go to S_HOLD.
//     S_HOLD: instr_valid=1. On instr_ready: instr_valid<=0, go to S_REQ.
//   pc+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0).
//   Redirect has priority over every other event. Let t = {redirect_pc[31:2],2'b00}; pc<=t in all cases:
//     S_REQ, !ready : stay in S_REQ; the request is withdrawn and the next cycle requests t
//                     (the memory port permits address change before acceptance).
//     S_REQ, ready  : request accepted; go to S_WAIT with drop<=1.
//     S_WAIT        : drop<=1. If resp_valid arrives the same cycle, discard it, clear drop, go to S_REQ.
//     S_WAIT, drop=1, resp_valid : discard the word, drop<=0, go to S_REQ (redirect pc kept).
//     S_HOLD        : instr_valid<=0, go to S_REQ. The held instr is discarded even if instr_ready=1;
//                     the consumer must not commit an instr in a cycle where it asserts redirect_valid.
//   Latency with zero-wait memory (ready=1, resp the next cycle): request at cycle 0,
//     instr_valid at cycle 2, next request the cycle after the handshake. Throughput is
//     1 instruction per 3 cycles. No prefetch. At most one request outstanding.
//   instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
//   imem_req_addr is stable while imem_req_valid=1 and imem_req_ready=0, except on redirect.
// TESTING
//   1 Reset release, RESET_PC=0, memory ready, 1-cycle response, instr_ready=1 ->
//     fetches 0x0, 0x4, 0x8 in order. instr_valid on cycles 2, 5, 8 with the matching instr_pc.
//   2 instr_ready held 0 for 5 cycles in S_HOLD -> instr/instr_pc unchanged, no new imem request.
//   3 imem_req_ready low for 3 cycles -> imem_req_addr held at 0x4 and valid stays high; then proceeds.
//   4 redirect_valid with redirect_pc=0x103 while in S_WAIT, response returns 2 cycles later ->
//     the response is dropped (instr_valid stays 0) and the next request addr is 0x100.
//   5 redirect in S_HOLD with instr_ready=1 in the same cycle -> instr_valid=0 next cycle,
//     request to the target, old word never re-presented.
//   6 pc=0xFFFF_FFFC fetched -> next request addr 0x0. reset_n=0 during S_WAIT -> state S_REQ,
//     pc=RESET_PC, instr_valid=0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch unit bus: imem request/response, decode handoff, redirect
interface instruction_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // master: the fetch unit; slave: memory plus decode/branch side
  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC holder and single-outstanding instruction fetcher
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          reset_n,
  instruction_fetch_unit_if.master      bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        req_q;
  logic        drop;
  logic [31:0] target;
  logic        unused_pc_bits;

  assign target         = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // Request is masked during reset so nothing is issued in the reset cycle itself.
  assign bus.imem_req_valid = req_q & reset_n;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_REQ;
      pc            <= {RESET_PC[31:2], 2'b00};
      drop          <= 1'b0;
      req_q         <= 1'b1;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.redirect_valid) begin
            pc <= target;
            if (bus.imem_req_ready) begin
              state <= S_WAIT;
              req_q <= 1'b0;
              drop  <= 1'b1;
            end
          end else if (bus.imem_req_ready) begin
            state <= S_WAIT;
            req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            pc <= target;
            if (bus.imem_resp_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              drop <= 1'b1;
            end
          end else if (bus.imem_resp_valid) begin
            state <= (drop) ? S_REQ : S_HOLD;
            req_q <= drop;
            if (drop) begin
              drop <= 1'b0;
            end else begin
              instr_q       <= bus.imem_resp_data;
              instr_pc_q    <= pc;
              pc            <= pc + 32'd4;
              instr_valid_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // A redirect discards the held word even if decode takes it this cycle.
          if (bus.redirect_valid || bus.instr_ready) begin
            if (bus.redirect_valid) begin
              pc <= target;
            end
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            state         <= S_REQ;
            req_q         <= 1'b1;
          end
        end
        default: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          cons_cyc[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_cons = 0;
  bit          ready_k = 1'b0;
  bit          iready_k = 1'b0;
  bit          redir_k = 1'b0;
  logic [31:0] redir_pc_k = 32'h0;
  int          lat = 1;
  bit          pend = 1'b0;
  bit          dead = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_pc = RPC;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, observe after settling, advance the reference model.
  task automatic cycle();
    bit   acc;
    bit   rsp;
    bit   redir;
    exp_t e;
    @(negedge clk);
    reset_n             = 1'b1;
    bus.imem_req_ready  = ready_k;
    bus.instr_ready     = iready_k;
    bus.redirect_valid  = redir_k;
    bus.redirect_pc     = redir_pc_k;
    rsp                 = pend && (cnt == 0);
    bus.imem_resp_valid = rsp;
    bus.imem_resp_data  = rsp ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    #1;
    redir = redir_k;
    acc   = bus.imem_req_valid && bus.imem_req_ready;
    if (acc) check_eq("req_addr", bus.imem_req_addr, exp_pc);
    if (bus.instr_valid && bus.instr_ready && !redir) begin
      if (sb.size() == 0) begin
        check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("instr_pc", bus.instr_pc, e.pc);
        check_eq("instr", bus.instr, e.data);
      end
      cons_cyc.push_back(cyc);
      n_cons++;
    end
    if (rsp) begin
      pend = 1'b0;
      if (!dead && !redir) exp_pc = exp_pc + 32'd4;
      dead = 1'b0;
    end else if (pend) begin
      cnt--;
      if (redir) dead = 1'b1;
    end
    if (acc) begin
      pend      = 1'b1;
      pend_addr = bus.imem_req_addr;
      cnt       = lat - 1;
      dead      = redir;
      if (!redir) sb.push_back('{exp_pc, mem_word(exp_pc)});
    end
    if (redir) begin
      sb.delete();
      exp_pc = {redir_pc_k[31:2], 2'b00};
    end
    redir_k = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n             = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    #1;
    check_eq("rst_req_gated", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_instr", bus.instr, NOP);
    check_eq("rst_instr_pc", bus.instr_pc, 32'h0);
    check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("rst_pc", bus.imem_req_addr, RPC);
    sb.delete();
    cons_cyc.delete();
    pend = 1'b0; dead = 1'b0; exp_pc = RPC; cyc = 0; n_cons = 0;
    ready_k = 1'b1; iready_k = 1'b1; redir_k = 1'b0; lat = 1;
  endtask

  task automatic run_until(string tag, int target, int budget);
    for (int i = 0; i < budget && n_cons < target; i++) cycle();
    check_eq(tag, 32'(n_cons), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t hold_e;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.instr_ready     = 1'b0;

    // 1: zero-wait memory, three fetches, valid on cycles 2/5/8
    do_reset();
    repeat (9) cycle();
    check_eq("t1_count", 32'(n_cons), 32'd3);
    for (int i = 0; i < 3; i++)
      if (cons_cyc.size() > i) check_eq("t1_cycle", 32'(cons_cyc[i]), 32'(2 + 3 * i));
    check_eq("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: decode stalls for 5 cycles while a word is held
    do_reset();
    iready_k = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (bus.instr_valid) break;
    end
    check_eq("t2_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("t2_sb", 32'(sb.size()), 32'd1);
    hold_e = (sb.size() > 0) ? sb[0] : '{32'h0, 32'h0};
    repeat (5) begin
      cycle();
      check_eq("t2_instr", bus.instr, hold_e.data);
      check_eq("t2_instr_pc", bus.instr_pc, hold_e.pc);
      check_eq("t2_no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    iready_k = 1'b1;
    run_until("t2_drain", 1, 5);

    // 3: memory stalls the second request for 3 cycles
    do_reset();
    cycle();
    ready_k = 1'b0;
    cycle();
    cycle();
    repeat (3) begin
      cycle();
      check_eq("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check_eq("t3_req_addr", bus.imem_req_addr, 32'h4);
    end
    ready_k = 1'b1;
    run_until("t3_drain", 2, 10);

    // 4: redirect while waiting, stale response arrives two cycles later
    do_reset();
    lat = 3;
    cycle();
    redir_k = 1'b1; redir_pc_k = 32'h0000_0103;
    repeat (3) begin
      cycle();
      check_eq("t4_no_valid", 32'(bus.instr_valid), 32'd0);
    end
    cycle();
    check_eq("t4_no_valid2", 32'(bus.instr_valid), 32'd0);
    check_eq("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("t4_req_addr", bus.imem_req_addr, 32'h100);
    lat = 1;
    run_until("t4_drain", 1, 10);

    // 5: redirect in hold with decode ready in the same cycle
    do_reset();
    iready_k = 1'b0;
    cycle();
    cycle();
    iready_k = 1'b1;
    redir_k = 1'b1; redir_pc_k = 32'h0000_0200;
    cycle();
    cycle();
    check_eq("t5_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("t5_instr_nop", bus.instr, NOP);
    check_eq("t5_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("t5_req_addr", bus.imem_req_addr, 32'h200);
    run_until("t5_drain", 1, 10);

    // 6: PC wrap at the top of memory, then reset during a wait
    do_reset();
    redir_k = 1'b1; redir_pc_k = 32'hFFFF_FFFF;
    cycle();
    run_until("t6_top", 1, 10);
    cycle();
    check_eq("t6_wrap_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("t6_wrap_addr", bus.imem_req_addr, 32'h0);
    run_until("t6_zero", 2, 10);
    lat = 3;
    cycle();
    do_reset();
    cycle();
    check_eq("t6_post_req", 32'(bus.imem_req_valid), 32'd1);
    check_eq("t6_post_addr", bus.imem_req_addr, RPC);
    check_eq("t6_post_valid", 32'(bus.instr_valid), 32'd0);
    run_until("t6_drain", 1, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
